regfile_param: RTL and testbench

Parametrised register file with two combinational read ports, one synchronous write port, optional hardwired-zero register 0, synchronous clear, and a coherent snapshot-dump port. The dump port streams every register to a debug or display consumer over a valid/ready handshake. It replaces fixed 8×8 register files in the datapath and feeds the board-level register display without one output bus per register.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_dump_fsm.sv | 62 ++++++
 rtl/regfile_param.sv | 84 ++++++++
 tb/tb_regfile_param.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the parametrised register file.
// Optional feature macro REGFILE_BYPASS_EN is consumed by regfile_param.
package regfile_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_fsm.sv
// Snapshot-dump sequencer: owns the IDLE/SEND state, beat index,
// valid/ready handshake and the one-cycle done pulse.
module regfile_dump_fsm
  import regfile_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dbg_start,
  input  logic          dbg_ready,
  output logic          dbg_valid,
  output logic          dbg_busy,
  output logic          dbg_done,
  output logic          snap_load,
  output logic [AW-1:0] idx
);

  dump_state_t state;
  logic        last_beat;

  // Strobe goes to the parent in the same cycle so the copy sees pre-write storage.
  assign snap_load = (state == IDLE) && dbg_start;
  assign last_beat = (idx == AW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      dbg_valid <= 1'b0;
      dbg_busy  <= 1'b0;
      dbg_done  <= 1'b0;
    end else begin
      dbg_done <= 1'b0;
      case (state)
        IDLE: begin
          if (dbg_start) begin
            state     <= SEND;
            idx       <= '0;
            dbg_valid <= 1'b1;
            dbg_busy  <= 1'b1;
          end
        end
        SEND: begin
          if (dbg_ready) begin
            if (last_beat) begin
              state     <= IDLE;
              dbg_valid <= 1'b0;
              dbg_busy  <= 1'b0;
              dbg_done  <= 1'b1;
            end
            // DEPTH is a power of two, so the last increment wraps idx to 0.
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports, one write port,
// optional hardwired r0 and a snapshot dump port. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module regfile_param
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic [AW-1:0]    wa3,
  input  logic             we3,
  input  logic [WIDTH-1:0] wd3,
  input  logic             dbg_start,
  input  logic             dbg_ready,
  output logic             dbg_valid,
  output logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic             dbg_busy,
  output logic             dbg_done
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] snap [DEPTH];
  logic             snap_load;
  logic [AW-1:0]    idx;
  logic             wr_en;

  assign wr_en = we3 && !((ZERO_REG != 0) && (wa3 == '0));

  // NOTE: storage is flops, not a RAM macro, so a synchronous clear of every entry is legal here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
        snap[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignment lets the snapshot copy the pre-edge contents of regs even when a write hits the same edge.
      if (snap_load) begin
        for (int i = 0; i < DEPTH; i++) snap[i] <= regs[i];
      end
      if (wr_en) regs[wa3] <= wd3;
    end
  end

  function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] ra);
    logic [WIDTH-1:0] v;
    v = regs[ra];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (wa3 == ra)) v = wd3;
`endif
    if ((ZERO_REG != 0) && (ra == '0)) v = '0;
    return v;
  endfunction

  // NOTE: read_port assigns v on every path, so these blocks are pure muxes with no latch.
  always_comb begin
    rd1 = read_port(ra1);
    rd2 = read_port(ra2);
  end

  assign dbg_addr = idx;
  assign dbg_data = snap[idx];

  regfile_dump_fsm #(.DEPTH(DEPTH)) u_dump_fsm (
    .clk       (clk),
    .rst       (rst),
    .dbg_start (dbg_start),
    .dbg_ready (dbg_ready),
    .dbg_valid (dbg_valid),
    .dbg_busy  (dbg_busy),
    .dbg_done  (dbg_done),
    .snap_load (snap_load),
    .idx       (idx)
  );

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench: directed test-plan sequences plus random traffic
// against a queue-based reference model, for ZERO_REG=1 and ZERO_REG=0 instances.
module tb_regfile_param;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, we3, dbg_start, dbg_ready;
  logic [AW-1:0] ra1, ra2, wa3;
  logic [W-1:0]  wd3;

  logic [W-1:0]  rd1_z, rd2_z, dd_z, rd1_n, rd2_n, dd_n;
  logic [AW-1:0] da_z, da_n;
  logic          dv_z, db_z, dn_z, dv_n, db_n, dn_n;

  regfile_param #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1)) u_z (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_z), .rd2(rd2_z),
    .wa3(wa3), .we3(we3), .wd3(wd3), .dbg_start(dbg_start), .dbg_ready(dbg_ready),
    .dbg_valid(dv_z), .dbg_addr(da_z), .dbg_data(dd_z), .dbg_busy(db_z), .dbg_done(dn_z)
  );

  regfile_param #(.WIDTH(W), .DEPTH(D), .ZERO_REG(0)) u_n (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
    .wa3(wa3), .we3(we3), .wd3(wd3), .dbg_start(dbg_start), .dbg_ready(dbg_ready),
    .dbg_valid(dv_n), .dbg_addr(da_n), .dbg_data(dd_n), .dbg_busy(db_n), .dbg_done(dn_n)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: register contents and the beats still owed by the dump.
  int  mz [D];
  int  mn [D];
  int  qz [$];
  int  qn [$];
  bit  busy;
  bit  exp_done;
  int  beats;
  int  dones;

  typedef struct { int addr; int data; } beat_t;
  beat_t cap [$];

  function automatic int exp_z(input int a);
    return (a == 0) ? 0 : mz[a];
  endfunction

  task automatic compare();
    check("rd1_z", rd1_z, exp_z(int'(ra1)));
    check("rd2_z", rd2_z, exp_z(int'(ra2)));
    check("rd1_n", rd1_n, mn[ra1]);
    check("rd2_n", rd2_n, mn[ra2]);
    check("valid_z", dv_z, busy);
    check("busy_z", db_z, busy);
    check("done_z", dn_z, exp_done);
    check("valid_n", dv_n, busy);
    check("done_n", dn_n, exp_done);
    if (busy) begin
      check("addr_z", da_z, D - qz.size());
      check("data_z", dd_z, qz[0]);
      check("addr_n", da_n, D - qn.size());
      check("data_n", dd_n, qn[0]);
    end
  endtask

  task automatic model_edge();
    bit d;
    d = 1'b0;
    if (rst) begin
      for (int k = 0; k < D; k++) begin
        mz[k] = 0;
        mn[k] = 0;
      end
      qz.delete();
      qn.delete();
      busy = 1'b0;
    end else begin
      if (busy) begin
        if (dbg_ready) begin
          void'(qz.pop_front());
          void'(qn.pop_front());
          beats++;
          if (qz.size() == 0) begin
            busy = 1'b0;
            d    = 1'b1;
            dones++;
          end
        end
      end else if (dbg_start) begin
        for (int k = 0; k < D; k++) begin
          qz.push_back(mz[k]);
          qn.push_back(mn[k]);
        end
        busy = 1'b1;
      end
      if (we3) begin
        if (wa3 != 0) mz[wa3] = int'(wd3);
        mn[wa3] = int'(wd3);
      end
    end
    exp_done = d;
  endtask

  // Inputs are set just after a negedge; outputs are checked 1ns later, then the edge is modelled.
  task automatic step();
    #1;
    compare();
    if (dv_z && dbg_ready) cap.push_back('{addr: int'(da_z), data: int'(dd_z)});
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic start_dump();
    dbg_start = 1'b1;
    step();
    dbg_start = 1'b0;
  endtask

  initial begin
    int d0, b0, n;

    rst = 1'b1; we3 = 1'b0; dbg_start = 1'b0; dbg_ready = 1'b0;
    ra1 = '0; ra2 = '0; wa3 = '0; wd3 = '0;
    for (int k = 0; k < D; k++) begin mz[k] = 0; mn[k] = 0; end
    busy = 1'b0; exp_done = 1'b0; beats = 0; dones = 0;
    @(posedge clk);
    @(negedge clk);
    step();
    rst = 1'b0;
    #1;
    check("rst_valid", dv_z, 0);
    check("rst_busy", db_z, 0);
    check("rst_done", dn_z, 0);
    check("rst_addr", da_z, 0);
    check("rst_data", dd_z, 0);
    check("rst_rd1", rd1_z, 0);

    // Basic write then read.
    we3 = 1'b1; wa3 = 3'd3; wd3 = 8'hA5;
    step();
    we3 = 1'b0; ra1 = 3'd3; ra2 = 3'd5;
    #1;
    check("wr_r3", rd1_z, 8'hA5);
    check("rd_r5", rd2_z, 8'h00);
    step();

    // r0 write: dropped when hardwired, stored otherwise.
    we3 = 1'b1; wa3 = 3'd0; wd3 = 8'hFF;
    step();
    we3 = 1'b0; ra1 = 3'd0;
    #1;
    check("r0_zero", rd1_z, 8'h00);
    check("r0_plain", rd1_n, 8'hFF);
    step();

    // Load rK = K + 0x10.
    for (int k = 0; k < D; k++) begin
      we3 = 1'b1; wa3 = AW'(k); wd3 = W'(k + 8'h10);
      step();
    end
    we3 = 1'b0;

    // Full-rate dump.
    cap.delete(); d0 = dones; b0 = beats; dbg_ready = 1'b1;
    start_dump();
    n = 0;
    while (dones == d0 && n < 50) begin step(); n++; end
    check("dump1_done", dones - d0, 1);
    check("dump1_beats", cap.size(), D);
    check("dump1_model_beats", beats - b0, D);
    for (int i = 0; i < cap.size() && i < D; i++) begin
      check("dump1_addr", cap[i].addr, i);
      check("dump1_data", cap[i].data, (i == 0) ? 0 : i + 8'h10);
    end
    #1;
    check("done_pulse", dn_z, 1);
    step();
    #1;
    check("done_single", dn_z, 0);

    // Stalled dump with a write to r2 during SEND.
    cap.delete(); d0 = dones; dbg_ready = 1'b0;
    start_dump();
    n = 0;
    while (dones == d0 && n < 100) begin
      dbg_ready = (n % 3 == 0);
      we3 = (n == 2); wa3 = 3'd2; wd3 = 8'h99;
      step();
      n++;
    end
    we3 = 1'b0;
    check("dump2_done", dones - d0, 1);
    check("dump2_beats", cap.size(), D);
    if (cap.size() > 2) check("dump2_r2", cap[2].data, 8'h12);
    ra1 = 3'd2;
    #1;
    check("r2_written", rd1_z, 8'h99);

    // Reset in the middle of a dump.
    cap.delete(); d0 = dones; dbg_ready = 1'b1;
    start_dump();
    n = 0;
    while (cap.size() < 4 && n < 50) begin step(); n++; end
    check("mid_beats", cap.size(), 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("mid_valid", dv_z, 0);
    for (int k = 0; k < 3; k++) step();
    check("mid_nodone", dones - d0, 0);
    for (int a = 0; a < D; a++) begin
      ra1 = AW'(a);
      #1;
      check("mid_rd_n", rd1_n, 0);
    end
    cap.delete(); d0 = dones;
    start_dump();
    n = 0;
    while (dones == d0 && n < 50) begin step(); n++; end
    check("dump3_beats", cap.size(), D);
    for (int i = 0; i < cap.size(); i++) check("dump3_zero", cap[i].data, 0);

    // Same-cycle write and read: old value now, new value after the edge.
    we3 = 1'b1; wa3 = 3'd6; wd3 = 8'h5A;
    step();
    wd3 = 8'h3C; ra1 = 3'd6;
    #1;
    check("fwd_old", rd1_z, 8'h5A);
    step();
    we3 = 1'b0;
    #1;
    check("fwd_new", rd1_z, 8'h3C);
    step();

    // Random traffic, including resets that collide with writes and dumps.
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      we3       = $urandom_range(0, 1);
      wa3       = AW'($urandom_range(0, D - 1));
      wd3       = W'($urandom);
      ra1       = AW'($urandom_range(0, D - 1));
      ra2       = AW'($urandom_range(0, D - 1));
      dbg_start = ($urandom_range(0, 5) == 0);
      dbg_ready = $urandom_range(0, 1);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
